// File: rtl/xc_malu_divrem_ctl.sv
// ---------------------------------------------------------------------------
// xc_malu_divrem_ctl
//
// Sequencer for the multi-cycle divide/remainder datapath of the MALU.
// Owns the iteration counter, the 64-bit accumulator and the 32-bit
// argument register, accepts DIV/DIVU/REM/REMU requests over a
// hold-until-ready handshake and walks the datapath through one load
// cycle, 32 iteration cycles and a completion cycle.
//
// Optional feature macro: XC_MALU_DIVZERO_FAST_EN
//   When defined, a request with a zero divisor bypasses the datapath and
//   completes one cycle after acceptance from a captured result register.
//   When undefined, divide by zero takes the normal iterative path; the
//   returned values are identical either way.
// ---------------------------------------------------------------------------
module xc_malu_divrem_ctl (
    input  logic        clock,
    input  logic        resetn,
    // pipeline side
    input  logic        valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        ready,
    output logic [31:0] result,
    output logic        busy,
    // datapath side
    output logic        dr_valid,
    output logic        dr_op_signed,
    output logic        dr_flush,
    output logic [5:0]  dr_counter,
    output logic [5:0]  dr_n_counter,
    output logic [63:0] dr_accumulator,
    output logic [31:0] dr_argument,
    input  logic [63:0] dr_n_accumulator,
    input  logic [32:0] dr_n_argument,
    input  logic        dr_finished,
    input  logic [31:0] dr_quotient,
    input  logic [31:0] dr_dividend
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] LAST_ITER = 6'd31;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [5:0]  counter_q;
    logic [5:0]  counter_d;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [31:0] arg_q;
    logic [31:0] arg_d;
    logic [1:0]  op_q;
    logic [1:0]  op_d;

    // Datapath start for an accepted request that needs the iterative path.
    logic        start_s;

`ifdef XC_MALU_DIVZERO_FAST_EN
    // Zero-divisor shortcut: result is known at acceptance time.
    logic        fast_start_s;
    logic        fast_q;
    logic        fast_d;
    logic [31:0] fres_q;
    logic [31:0] fres_d;
`endif

    // The datapath done flag is a datapath health indicator only and bit 32
    // of the next argument is a datapath-internal carry; neither steers the
    // sequencer.
    logic        unused_inputs_s;
    assign unused_inputs_s = dr_n_argument[32] ^ dr_finished;

    // Decide whether a request is accepted this cycle and which path it takes.
    always_comb begin
        start_s = 1'b0;
`ifdef XC_MALU_DIVZERO_FAST_EN
        fast_start_s = 1'b0;
`endif
        if ((state_q == S_IDLE) && valid && !flush) begin
`ifdef XC_MALU_DIVZERO_FAST_EN
            if (rs2 == 32'd0) begin
                fast_start_s = 1'b1;
            end else begin
                start_s = 1'b1;
            end
`else
            start_s = 1'b1;
`endif
        end else begin
            start_s = 1'b0;
        end
    end

    // Next-state and register-update logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        acc_d     = acc_q;
        arg_d     = arg_q;
        op_d      = op_q;
`ifdef XC_MALU_DIVZERO_FAST_EN
        fast_d    = fast_q;
        fres_d    = fres_q;
`endif
        if (flush) begin
            // Abandon whatever is in flight; flush also beats a new request.
            state_d   = S_IDLE;
            counter_d = 6'd0;
`ifdef XC_MALU_DIVZERO_FAST_EN
            fast_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        acc_d     = dr_n_accumulator;
                        arg_d     = dr_n_argument[31:0];
                        counter_d = 6'd0;
                        op_d      = op;
                        state_d   = S_RUN;
`ifdef XC_MALU_DIVZERO_FAST_EN
                        fast_d    = 1'b0;
                    end else if (fast_start_s) begin
                        op_d      = op;
                        fast_d    = 1'b1;
                        fres_d    = op[1] ? rs1 : 32'hFFFF_FFFF;
                        state_d   = S_DONE;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_d     = dr_n_accumulator;
                    arg_d     = dr_n_argument[31:0];
                    counter_d = counter_q + 6'd1;
                    if (counter_q == LAST_ITER) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    // Result is presented this cycle; registers hold.
                    state_d = S_IDLE;
                end
                default: begin
                    // Unreachable encoding: recover to a clean idle state.
                    state_d   = S_IDLE;
                    counter_d = 6'd0;
                end
            endcase
        end
    end

    // Sequencer state registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            counter_q <= 6'd0;
            acc_q     <= 64'd0;
            arg_q     <= 32'd0;
            op_q      <= 2'd0;
`ifdef XC_MALU_DIVZERO_FAST_EN
            fast_q    <= 1'b0;
            fres_q    <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            acc_q     <= acc_d;
            arg_q     <= arg_d;
            op_q      <= op_d;
`ifdef XC_MALU_DIVZERO_FAST_EN
            fast_q    <= fast_d;
            fres_q    <= fres_d;
`endif
        end
    end

    // A flushed operation never reports completion, even from DONE.
    assign ready          = (state_q == S_DONE) && !flush;
    assign busy           = (state_q == S_RUN) || (state_q == S_DONE);
    assign dr_valid       = start_s;
    assign dr_op_signed   = ~op[0];
    assign dr_flush       = flush || (state_q == S_DONE);
    assign dr_counter     = counter_q;
    assign dr_n_counter   = counter_q + 6'd1;
    assign dr_accumulator = acc_q;
    assign dr_argument    = arg_q;

    // Result select: remainder for REM/REMU, quotient otherwise, zero when idle.
    always_comb begin
        result = 32'd0;
        if (ready) begin
`ifdef XC_MALU_DIVZERO_FAST_EN
            if (fast_q) begin
                result = fres_q;
            end else begin
                result = op_q[1] ? dr_dividend : dr_quotient;
            end
`else
            result = op_q[1] ? dr_dividend : dr_quotient;
`endif
        end else begin
            result = 32'd0;
        end
    end

endmodule

// File: tb/tb_xc_malu_divrem_ctl.sv
// ---------------------------------------------------------------------------
// Testbench for xc_malu_divrem_ctl.
// Provides a restoring-division datapath around the controller, issues
// directed and random requests, and checks results and completion cycles
// through a scoreboard against a plain-arithmetic reference.
// ---------------------------------------------------------------------------
module tb_xc_malu_divrem_ctl;

    logic        clock;
    logic        resetn;
    logic        valid;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        ready;
    logic [31:0] result;
    logic        busy;
    logic        dr_valid;
    logic        dr_op_signed;
    logic        dr_flush;
    logic [5:0]  dr_counter;
    logic [5:0]  dr_n_counter;
    logic [63:0] dr_accumulator;
    logic [31:0] dr_argument;
    logic [63:0] dr_n_accumulator;
    logic [32:0] dr_n_argument;
    logic        dr_finished;
    logic [31:0] dr_quotient;
    logic [31:0] dr_dividend;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] exp_res_q[$];
    int          exp_cyc_q[$];
    bit          exp_slow_q[$];

    xc_malu_divrem_ctl dut (
        .clock(clock), .resetn(resetn), .valid(valid), .op(op), .rs1(rs1),
        .rs2(rs2), .flush(flush), .ready(ready), .result(result), .busy(busy),
        .dr_valid(dr_valid), .dr_op_signed(dr_op_signed), .dr_flush(dr_flush),
        .dr_counter(dr_counter), .dr_n_counter(dr_n_counter),
        .dr_accumulator(dr_accumulator), .dr_argument(dr_argument),
        .dr_n_accumulator(dr_n_accumulator), .dr_n_argument(dr_n_argument),
        .dr_finished(dr_finished), .dr_quotient(dr_quotient),
        .dr_dividend(dr_dividend)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // cycle index used for latency checks
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- datapath model (restoring division) ----------------
    function automatic logic [31:0] abs32(input logic [31:0] x, input logic s);
        return (s && x[31]) ? (32'd0 - x) : x;
    endfunction

    logic        dp_run, dp_fin, dp_neg_a, dp_neg_b, dp_bz;
    logic [5:0]  dp_steps;
    logic [32:0] dp_r33;
    logic [32:0] dp_diff;

    // datapath run/done flags and operand signs
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dp_run <= 1'b0; dp_fin <= 1'b0; dp_steps <= 6'd0;
            dp_neg_a <= 1'b0; dp_neg_b <= 1'b0; dp_bz <= 1'b0;
        end else if (dr_flush) begin
            dp_run <= 1'b0; dp_fin <= 1'b0;
        end else if (dr_valid) begin
            dp_run   <= 1'b1; dp_fin <= 1'b0; dp_steps <= 6'd0;
            dp_neg_a <= dr_op_signed & rs1[31];
            dp_neg_b <= dr_op_signed & rs2[31];
            dp_bz    <= (rs2 == 32'd0);
        end else if (dp_run) begin
            dp_steps <= dp_steps + 6'd1;
            if (dp_steps == 6'd31) begin
                dp_run <= 1'b0; dp_fin <= 1'b1;
            end
        end
    end

    // next accumulator/argument: load on start, otherwise one division step
    always_comb begin
        dp_r33  = dr_accumulator[63:31];
        dp_diff = dp_r33 - {1'b0, dr_argument};
        if (dr_valid) begin
            dr_n_accumulator = {32'd0, abs32(rs1, dr_op_signed)};
            dr_n_argument    = {1'b1, abs32(rs2, dr_op_signed)};
        end else begin
            if (dp_r33 >= {1'b0, dr_argument})
                dr_n_accumulator = {dp_diff[31:0], dr_accumulator[30:0], 1'b1};
            else
                dr_n_accumulator = {dr_accumulator[62:0], 1'b0};
            dr_n_argument = {dr_accumulator[5], dr_argument};
        end
    end

    assign dr_finished = dp_fin;
    assign dr_quotient = ((dp_neg_a ^ dp_neg_b) && !dp_bz) ? (32'd0 - dr_accumulator[31:0])
                                                           : dr_accumulator[31:0];
    assign dr_dividend = dp_neg_a ? (32'd0 - dr_accumulator[63:32]) : dr_accumulator[63:32];

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        sa = a; sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a; r = 32'd0;
            end else begin
                q = sa / sb; r = sa % sb;
            end
        end else begin
            q = a / b; r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (resetn) begin
            n_cmp++;
            if (ready) begin
                if (exp_res_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ready: got result %h at cycle %0d, expected no ready",
                             result, cyc);
                end else begin
                    logic [31:0] er;
                    int          ec;
                    bit          es;
                    er = exp_res_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    es = exp_slow_q.pop_front();
                    if (result !== er) begin
                        n_err++;
                        $display("FAIL result: got %h expected %h", result, er);
                    end
                    n_cmp++;
                    if (cyc != ec) begin
                        n_err++;
                        $display("FAIL latency: ready at cycle %0d expected %0d", cyc, ec);
                    end
                    if (es) begin
                        n_cmp++;
                        if (dr_finished !== 1'b1) begin
                            n_err++;
                            $display("FAIL dp_finished: got %b in DONE expected 1", dr_finished);
                        end
                    end
                end
            end else if (result !== 32'd0) begin
                n_err++;
                $display("FAIL idle_result: got %h expected 0", result);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int lat;
        bit seen;
        @(posedge clock); #1;
        valid = 1'b1; op = o; rs1 = a; rs2 = b; flush = 1'b0;
        lat = 33;
`ifdef XC_MALU_DIVZERO_FAST_EN
        if (b == 32'd0) lat = 1;
`endif
        exp_res_q.push_back(ref_res(o, a, b));
        exp_cyc_q.push_back(cyc + lat);
        exp_slow_q.push_back(lat == 33);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL timeout: no ready for op %0d %h/%h, expected one", o, a, b);
            exp_res_q.delete(); exp_cyc_q.delete(); exp_slow_q.delete();
        end
    endtask

    task automatic end_req();
        @(posedge clock); #1;
        valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  {63'd0, ready}, 64'd0);
        chk({tag, "_result"}, {32'd0, result}, 64'd0);
        chk({tag, "_busy"},   {63'd0, busy}, 64'd0);
        chk({tag, "_dvalid"}, {63'd0, dr_valid}, 64'd0);
        chk({tag, "_dflush"}, {63'd0, dr_flush}, {63'd0, flush});
        chk({tag, "_cnt"},    {58'd0, dr_counter}, 64'd0);
        chk({tag, "_ncnt"},   {58'd0, dr_n_counter}, 64'd1);
        chk({tag, "_acc"},    dr_accumulator, 64'd0);
        chk({tag, "_arg"},    {32'd0, dr_argument}, 64'd0);
    endtask

    initial begin
        bit ok;
        resetn = 1'b0; valid = 1'b0; op = 2'd0; rs1 = 32'd0; rs2 = 32'd0; flush = 1'b0;
        #12;
        chk_reset_outputs("por");
        @(negedge clock); #2; resetn = 1'b1;

        // directed cases
        do_op(2'b01, 32'd100, 32'd7);
        do_op(2'b11, 32'd100, 32'd7);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        do_op(2'b00, 32'd5, 32'd0);
        do_op(2'b10, 32'd5, 32'd0);
        end_req();

        // flush mid-run at counter 10
        @(posedge clock); #1;
        valid = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (busy && dr_counter == 6'd10) begin
                ok = 1'b1;
                break;
            end
        end
        chk("flush_reach_cnt10", {63'd0, ok}, 64'd1);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; valid = 1'b0;
        @(negedge clock);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_cnt", {58'd0, dr_counter}, 64'd0);
        repeat (40) @(negedge clock);
        do_op(2'b01, 32'd9, 32'd3);
        end_req();

        // flush beats a request arriving in IDLE
        @(posedge clock); #1;
        valid = 1'b1; flush = 1'b1; op = 2'b01; rs1 = 32'd9; rs2 = 32'd3;
        #1;
        chk("flushprio_dvalid", {63'd0, dr_valid}, 64'd0);
        chk("flushprio_dflush", {63'd0, dr_flush}, 64'd1);
        @(posedge clock); #1;
        flush = 1'b0; valid = 1'b0;
        @(negedge clock);
        chk("flushprio_busy", {63'd0, busy}, 64'd0);

        // back-to-back: second ready 34 cycles after the first
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1);
        do_op(2'b11, 32'd17, 32'd5);
        end_req();

        // asynchronous reset in the middle of RUN
        @(posedge clock); #1;
        valid = 1'b1; op = 2'b11; rs1 = 32'd12345; rs2 = 32'd77;
        repeat (15) @(negedge clock);
        #2;
        resetn = 1'b0; valid = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clock);
        #2; resetn = 1'b1;
        do_op(2'b01, 32'd100, 32'd7);
        end_req();

        // randomized operations
        for (int n = 0; n < 16; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [1:0]  o;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            do_op(o, a, b);
            if ($urandom_range(0, 1) == 1) end_req();
        end
        end_req();

        repeat (5) @(negedge clock);
        chk("sb_drained", 64'(exp_res_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xc_malu_divrem_ctl.md
# xc_malu_divrem_ctl

Sequencer for the multi-cycle divide/remainder datapath inside the MALU. It owns the shared iteration state (counter, 64-bit accumulator, 32-bit argument), accepts DIV/DIVU/REM/REMU requests from the execute stage over a hold-until-ready handshake, and steps the divider datapath through its load, 32 iterations and completion. It then returns the selected result and clears the datapath for the next operation.

## Interface
Parameters: none.

Ports, pipeline side:
- clock  in  1  core clock; all state updates on its rising edge
- resetn  in  1  asynchronous, active-low reset
- valid  in  1  request present; held with operands stable until ready
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1  in  32  dividend
- rs2  in  32  divisor
- flush  in  1  abandon the current operation
- ready  out  1  one-cycle pulse; result valid this cycle
- result  out  32  quotient (DIV/DIVU) or remainder (REM/REMU); 0 when ready=0
- busy  out  1  high in RUN or DONE

Ports, datapath side:
- dr_valid  out  1  start strobe to the datapath
- dr_op_signed  out  1  equals ~op[0]
- dr_flush  out  1  clears datapath done/run flags
- dr_counter  out  6  iteration index
- dr_n_counter  out  6  dr_counter+1
- dr_accumulator  out  64  accumulator register
- dr_argument  out  32  argument register
- dr_n_accumulator  in  64  next accumulator from the datapath
- dr_n_argument  in  33  next argument from the datapath; bit 32 is ignored
- dr_finished  in  1  datapath done flag
- dr_quotient  in  32  signed-corrected quotient
- dr_dividend  in  32  signed-corrected remainder

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE, with counter=0, accumulator=0 and argument=0.
- IDLE
  - On valid && !flush: dr_valid=1 this cycle, accumulator/argument load dr_n_*, counter<=0, next state RUN.
  - Otherwise the state is held.
- RUN
  - Every cycle: accumulator/argument load dr_n_*, counter<=counter+1.
  - At counter==31: next state DONE.
- DONE
  - Requires dr_finished=1. If dr_finished=0 here, that is a datapath bug; the bench flags it.
  - ready=1. result = op[1] ? dr_dividend : dr_quotient.
  - dr_flush=1. Next state IDLE. Counter, accumulator and argument hold.
- dr_flush = flush || state==DONE.
- flush in any state: next state IDLE, counter<=0. No ready is produced for the flushed operation. flush has priority over a request arriving in the same cycle.
- Arithmetic comes entirely from the datapath; the controller does no arithmetic except the counter increment.
  - Divide by zero: quotient 0xFFFFFFFF, remainder rs1.
  - Overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- Asynchronous reset mid-operation: immediately returns to IDLE and clears all registers. ready, dr_valid and busy go low at once.

## Timing
- Request first seen in IDLE at cycle T: ready at T+33 (1 load cycle, 32 RUN cycles, DONE).
- The next request can be accepted in IDLE at T+34, so back-to-back operations repeat every 34 cycles.
- ready lasts exactly one cycle and cannot be stalled. The pipeline must capture result in that cycle.
- Outputs during reset: ready=0, result=0, busy=0, dr_valid=0, dr_flush=flush, dr_counter=0, dr_n_counter=1, dr_accumulator=0, dr_argument=0.

## Configuration
- XC_MALU_DIVZERO_FAST_EN defined:
  - In IDLE, valid && !flush && rs2==0 skips the datapath: dr_valid stays 0 and the next state is DONE.
  - DONE then produces result 0xFFFFFFFF (DIV/DIVU) or rs1 (REM/REMU) from a captured result register, with dr_flush=1. Latency is T+1.
- Undefined: divide by zero takes the normal 33-cycle path. Result values are identical either way.

## Test plan
- DIVU 100/7 at T: ready at T+33 with result=14; REMU with the same operands returns 2.
- DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM with the same operands returns 0. REM 0xFFFFFFF9 % 2 returns 0xFFFFFFFF.
- DIV 5/0 returns 0xFFFFFFFF and REM 5/0 returns 5. Latency is 1 cycle with XC_MALU_DIVZERO_FAST_EN and 33 cycles without.
- flush asserted at counter=10 during DIVU 1000/3: no ready, state returns to IDLE. A following DIVU 9/3 returns 3 at +33.
- Back-to-back DIVU 0xFFFFFFFF/1 then REMU 17/5: results 0xFFFFFFFF then 2, with the second ready exactly 34 cycles after the first.
- resetn pulsed low mid-RUN: all outputs take reset values asynchronously. The next request completes correctly.
